// File: rtl/bus_arbiter_mux.sv
// Registered, fixed-priority CPU bus multiplexer with IDLE/DRIVE/HOLD tracking,
// sticky conflict detection and transfer counting. Optional macro: BUS_CONFLICT_CNT_EN.
`timescale 1ns/1ps
module bus_arbiter_mux #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  localparam int SELW = $clog2(NSRC)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_out,
  input  logic                  hold_en,
  input  logic                  conflict_clr,
  output logic [WIDTH-1:0]      bus_out,
  output logic [SELW-1:0]       bus_sel,
  output logic                  bus_valid,
  output logic [1:0]            bus_state,
  output logic                  conflict,
  output logic [7:0]            conflict_cnt,
  output logic [15:0]           xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    HOLD  = 2'b10
  } busState_t;

  busState_t        stateReg, stateNext;
  logic [WIDTH-1:0] busOutReg, busOutNext;
  logic [SELW-1:0]  busSelReg, busSelNext;
  logic             validReg, validNext;
  logic             conflictReg, conflictNext;
  logic [15:0]      xferReg, xferNext;

  logic [WIDTH-1:0] srcArr [NSRC];
  logic [SELW-1:0]  winIdx;
  logic             anyEn;
  logic             multiHot;
  logic [WIDTH-1:0] winData;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : gUnpack
      assign srcArr[gi] = src_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan from the top so the lowest asserted index is the last one written.
  always_comb begin
    winIdx = '0;
    anyEn  = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_out[i]) begin
        winIdx = SELW'(i);
        anyEn  = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multiHot = |(src_out & (src_out - NSRC'(1)));
  assign winData  = srcArr[winIdx];

  always_comb begin
    stateNext  = stateReg;
    busOutNext = busOutReg;
    busSelNext = busSelReg;
    validNext  = 1'b0;
    xferNext   = xferReg;
    if (anyEn) begin
      stateNext  = DRIVE;
      busOutNext = winData;
      busSelNext = winIdx;
      validNext  = 1'b1;
      xferNext   = xferReg + 16'd1;
    end else if (hold_en) begin
      stateNext = (stateReg == IDLE) ? IDLE : HOLD;
    end else begin
      stateNext  = IDLE;
      busOutNext = '0;
      busSelNext = '0;
    end
  end

  always_comb begin
    conflictNext = conflictReg;
    if (multiHot)
      conflictNext = 1'b1;
    else if (conflict_clr)
      conflictNext = 1'b0;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      stateReg    <= IDLE;
      busOutReg   <= '0;
      busSelReg   <= '0;
      validReg    <= 1'b0;
      conflictReg <= 1'b0;
      xferReg     <= '0;
    end else begin
      stateReg    <= stateNext;
      busOutReg   <= busOutNext;
      busSelReg   <= busSelNext;
      validReg    <= validNext;
      conflictReg <= conflictNext;
      xferReg     <= xferNext;
    end
  end

`ifdef BUS_CONFLICT_CNT_EN
  logic [7:0] confCntReg, confCntNext;

  // A conflict in the same cycle as a clear restarts the count at one.
  always_comb begin
    confCntNext = confCntReg;
    if (multiHot) begin
      if (conflict_clr)
        confCntNext = 8'd1;
      else if (confCntReg != 8'hFF)
        confCntNext = confCntReg + 8'd1;
    end else if (conflict_clr) begin
      confCntNext = 8'd0;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear)
      confCntReg <= 8'd0;
    else
      confCntReg <= confCntNext;
  end

  assign conflict_cnt = confCntReg;
`else
  assign conflict_cnt = 8'd0;
`endif

  assign bus_out   = busOutReg;
  assign bus_sel   = busSelReg;
  assign bus_valid = validReg;
  assign bus_state = stateReg;
  assign conflict  = conflictReg;
  assign xfer_cnt  = xferReg;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Scoreboard bench for bus_arbiter_mux: stimulus queues expected outputs tagged
// with the clock edge that produces them; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_bus_arbiter_mux;

  localparam int WIDTH = 32;
  localparam int NSRC  = 24;
  localparam logic [1:0] ST_IDLE = 2'b00, ST_DRIVE = 2'b01, ST_HOLD = 2'b10;

  logic                  clock = 1'b0;
  logic                  clear;
  logic [NSRC*WIDTH-1:0] srcData;
  logic [NSRC-1:0]       srcOut;
  logic                  holdEn;
  logic                  conflictClr;
  logic [WIDTH-1:0]      busOut;
  logic [4:0]            busSel;
  logic                  busValid;
  logic [1:0]            busState;
  logic                  conflict;
  logic [7:0]            conflictCnt;
  logic [15:0]           xferCnt;

  bus_arbiter_mux #(.WIDTH(WIDTH), .NSRC(NSRC)) dut (
    .clock(clock), .clear(clear), .src_data(srcData), .src_out(srcOut),
    .hold_en(holdEn), .conflict_clr(conflictClr), .bus_out(busOut),
    .bus_sel(busSel), .bus_valid(busValid), .bus_state(busState),
    .conflict(conflict), .conflict_cnt(conflictCnt), .xfer_cnt(xferCnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          edgeNo;
    string       name;
    logic [31:0] bo;
    logic [4:0]  sel;
    logic        v;
    logic [1:0]  st;
    logic        cf;
    logic [7:0]  cc;
    logic [15:0] xc;
  } exp_t;

  exp_t expQ[$];
  int   edgeCnt = 0;
  int   checks  = 0;
  int   fails   = 0;

  logic [15:0] expXfer = 16'd0;
  logic        expConf = 1'b0;
  logic [7:0]  expCnt  = 8'd0;

  always @(posedge clock) edgeCnt <= edgeCnt + 1;

  task automatic compare(input exp_t e);
    checks++;
    if (busOut !== e.bo || busSel !== e.sel || busValid !== e.v || busState !== e.st ||
        conflict !== e.cf || conflictCnt !== e.cc || xferCnt !== e.xc) begin
      fails++;
      $display("FAIL %s: got bus=%h sel=%0d valid=%b state=%b conf=%b ccnt=%0d xfer=%0d; want bus=%h sel=%0d valid=%b state=%b conf=%b ccnt=%0d xfer=%0d",
               e.name, busOut, busSel, busValid, busState, conflict, conflictCnt, xferCnt,
               e.bo, e.sel, e.v, e.st, e.cf, e.cc, e.xc);
    end else begin
      $display("ok   %s: bus=%h sel=%0d state=%b conf=%b ccnt=%0d xfer=%0d",
               e.name, busOut, busSel, busState, conflict, conflictCnt, xferCnt);
    end
  endtask

  always @(negedge clock) begin
    while (expQ.size() > 0 && expQ[0].edgeNo == edgeCnt) begin
      exp_t e;
      e = expQ.pop_front();
      compare(e);
    end
  end

  // Apply one cycle of enables at a negedge; bus fields are hand values, counters tracked here.
  task automatic drive(input string nm, input logic [NSRC-1:0] en, input logic hold,
                       input logic clr, input logic [31:0] bo, input logic [4:0] sel,
                       input logic v, input logic [1:0] st, input bit chk);
    exp_t e;
    srcOut = en; holdEn = hold; conflictClr = clr;
    if (en != '0) expXfer = expXfer + 16'd1;
    if ($countones(en) >= 2) begin
      expConf = 1'b1;
`ifdef BUS_CONFLICT_CNT_EN
      expCnt = clr ? 8'd1 : ((expCnt == 8'hFF) ? 8'hFF : expCnt + 8'd1);
`endif
    end else if (clr) begin
      expConf = 1'b0;
      expCnt  = 8'd0;
    end
    if (chk) begin
      e.edgeNo = edgeCnt + 1; e.name = nm; e.bo = bo; e.sel = sel; e.v = v; e.st = st;
      e.cf = expConf; e.cc = expCnt; e.xc = expXfer;
      expQ.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic checkNow(input string nm);
    exp_t e;
    e.edgeNo = edgeCnt; e.name = nm; e.bo = '0; e.sel = '0; e.v = 1'b0; e.st = ST_IDLE;
    e.cf = 1'b0; e.cc = 8'd0; e.xc = 16'd0;
    compare(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b0; srcOut = '0; holdEn = 1'b0; conflictClr = 1'b0;
    for (int i = 0; i < NSRC; i++) srcData[i*WIDTH +: WIDTH] = 32'(i + 1);
    #3;
    checkNow("reset");
    @(negedge clock);
    clear = 1'b1;

    for (int i = 0; i < NSRC; i++)
      drive($sformatf("sweep%0d", i), NSRC'(1) << i, 1'b0, 1'b0, 32'(i + 1), 5'(i), 1'b1, ST_DRIVE, 1'b1);

    drive("holdR5", NSRC'(1) << 5, 1'b1, 1'b0, 32'h6, 5'd5, 1'b1, ST_DRIVE, 1'b1);
    for (int k = 0; k < 3; k++)
      drive($sformatf("hold%0d", k), '0, 1'b1, 1'b0, 32'h6, 5'd5, 1'b0, ST_HOLD, 1'b1);
    drive("holdRelease", '0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, ST_IDLE, 1'b1);
    drive("idleHoldEn", '0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, ST_IDLE, 1'b1);

    drive("conflict3_17", (NSRC'(1) << 3) | (NSRC'(1) << 17), 1'b0, 1'b0, 32'h4, 5'd3, 1'b1, ST_DRIVE, 1'b1);
    drive("conflictSticky", '0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, ST_IDLE, 1'b1);
    drive("conflictClr", NSRC'(1), 1'b0, 1'b1, 32'h1, 5'd0, 1'b1, ST_DRIVE, 1'b1);
    drive("clrWithConflict", NSRC'(6), 1'b0, 1'b1, 32'h2, 5'd1, 1'b1, ST_DRIVE, 1'b1);

    for (int k = 0; k < 300; k++)
      drive($sformatf("sat%0d", k), NSRC'(1) | (NSRC'(1) << 23), 1'b0, 1'b0, 32'h1, 5'd0, 1'b1, ST_DRIVE, 1'b1);

    // Run the transfer counter round to 0xFFFF and over the wrap, checking near the edge.
    while (expXfer != 16'd0)
      drive("xferWrap", NSRC'(1) << 7, 1'b0, 1'b0, 32'h8, 5'd7, 1'b1, ST_DRIVE,
            (expXfer >= 16'hFFFD) || (expXfer == 16'd0));
    drive("xferAfterWrap", NSRC'(1) << 7, 1'b0, 1'b0, 32'h8, 5'd7, 1'b1, ST_DRIVE, 1'b1);

    drive("preResetZhigh", NSRC'(1) << 18, 1'b0, 1'b0, 32'h13, 5'd18, 1'b1, ST_DRIVE, 1'b1);
    #2 clear = 1'b0;
    expXfer = 16'd0; expConf = 1'b0; expCnt = 8'd0;
    #1 checkNow("asyncReset");
    @(negedge clock);
    checkNow("resetHeld");
    clear = 1'b1;
    drive("afterResetMDR", NSRC'(1) << 21, 1'b0, 1'b0, 32'd22, 5'd21, 1'b1, ST_DRIVE, 1'b1);
    srcOut = '0;

    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clock);
    if (expQ.size() > 0) begin
      checks++; fails++;
      $display("FAIL drain: %0d expected entries left, want 0", expQ.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_mux.md
# bus_arbiter_mux

Parametrised, registered successor to the datapath bus multiplexer. It selects one of `NSRC` register sources onto the shared `WIDTH`-bit CPU bus from one-hot `*out` enables, and resolves multi-driver conflicts by fixed priority. It registers the bus value together with the encoded source index. It also tracks the bus state (idle/drive/hold), flags and counts conflicts, and counts bus transfers. It sits between the register file and special registers (R0–R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C) and every bus consumer.

## Interface
- `WIDTH`, 32, bus data width in bits (≥1)
- `NSRC`, 24, number of bus sources (2..64)
- `SELW`, `$clog2(NSRC)`, width of encoded source index (derived; not overridden)

- `clock`  in  1  rising-edge clock
- `clear`  in  1  reset; one clock, asynchronous, active-low
- `src_data`  in  NSRC*WIDTH  flattened source values; source i occupies bits [i*WIDTH +: WIDTH]
- `src_out`  in  NSRC  per-source output enables (intended one-hot)
- `hold_en`  in  1  when 1, bus retains last driven value while no enable is active
- `conflict_clr`  in  1  clears sticky conflict flag and conflict counter
- `bus_out`  out  WIDTH  registered bus value
- `bus_sel`  out  SELW  registered index of the source that produced `bus_out`
- `bus_valid`  out  1  registered; 1 when `bus_out` came from a source this cycle
- `bus_state`  out  2  00 IDLE, 01 DRIVE, 10 HOLD
- `conflict`  out  1  sticky; set when ≥2 enables were seen in the same cycle
- `conflict_cnt`  out  8  saturating count of conflict cycles
- `xfer_cnt`  out  16  wrapping count of DRIVE cycles

## Operation
- Winner: lowest-index asserted bit of `src_out`. Priority encoder is combinational; all outputs are registered.
- State machine, evaluated each rising edge:
  - any enable → DRIVE: `bus_out` = winner data, `bus_sel` = winner index, `bus_valid`=1, `xfer_cnt`+1 (16'hFFFF wraps to 0).
  - no enable, `hold_en`=1, current state DRIVE or HOLD → HOLD: `bus_out` and `bus_sel` unchanged, `bus_valid`=0.
  - no enable, `hold_en`=1, current state IDLE → stay IDLE.
  - no enable, `hold_en`=0 → IDLE: `bus_out`=0, `bus_sel`=0, `bus_valid`=0.
- Conflict: population count of `src_out` ≥2 → `conflict` set to 1 and `conflict_cnt`+1, saturating at 8'hFF. The winner still drives per priority.
- `conflict_clr`: `conflict`←0, `conflict_cnt`←0. If a conflict occurs in the same cycle, set wins: `conflict`=1, `conflict_cnt`=1.
- Reset (`clear`=0, asynchronous, any time including mid-transfer): `bus_out`=0, `bus_sel`=0, `bus_valid`=0, `bus_state`=IDLE, `conflict`=0, `conflict_cnt`=0, `xfer_cnt`=0. Outputs change immediately on assertion. The first edge after deassertion evaluates normally.

## Timing
- Latency 1 cycle: enables/data sampled at edge N appear on all outputs after edge N.
- Source data is sampled only at the edge. Data changes between edges have no effect.
- `bus_state`, `bus_valid`, `conflict`, `conflict_cnt` and `xfer_cnt` update on the same edge as `bus_out`.
- Back-to-back different sources on consecutive cycles give consecutive `bus_out` values with no bubble.
- `hold_en` is sampled at the edge only; changing it during HOLD takes effect at the next edge.

## Configuration
- `BUS_CONFLICT_CNT_EN` defined: `conflict_cnt` counter is implemented as specified.
- Not defined: `conflict_cnt` is constant 0, no counter flops are built, and `conflict_clr` affects only `conflict`. All other behaviour is identical.

## Test plan
- Reset then sweep: source i = i+1, enable each of 24 sources one-hot for one cycle → `bus_out` = i+1, `bus_sel` = i, `bus_valid`=1 one cycle later; `xfer_cnt`=24 at the end.
- Hold: drive R5 (0x6), then no enables with `hold_en`=1 for 3 cycles → `bus_out`=0x6, `bus_sel`=5, `bus_state`=HOLD, `bus_valid`=0. Then `hold_en`=0 → `bus_out`=0, IDLE.
- Conflict: enable sources 3 and 17 together → `bus_out`=0x4, `bus_sel`=3, `conflict`=1, `conflict_cnt`=1. Pulse `conflict_clr` together with another conflict → `conflict`=1, `conflict_cnt`=1.
- Saturation/wrap: 300 conflict cycles → `conflict_cnt`=0xFF. Preload via 65535 DRIVE cycles, then one more → `xfer_cnt`=0.
- Async reset mid-DRIVE: assert `clear`=0 between edges while `bus_out`=0x13 → all outputs 0 and IDLE before the next edge. Release, drive MDR → value appears after one edge.
- Build without `BUS_CONFLICT_CNT_EN`: repeat the conflict test → `conflict`=1, `conflict_cnt`=0.
